// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU add/sub issue path: op encodings, operand
// width and the in-flight tracker entry.
package fpu_pkg;

  localparam logic FPU_OP_ADD = 1'b0;
  localparam logic FPU_OP_SUB = 1'b1;
  localparam int   FPU_W      = 32;

  // Sized for the largest supported requester count (8).
  localparam int   FPU_TAG_W  = 3;

  typedef struct packed {
    logic                 valid;
    logic [FPU_TAG_W-1:0] tag;
  } fpu_tag_t;

endpackage

// File: rtl/fpu_rr_arb.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NREQ. Produces nothing while hold is high.
module fpu_rr_arb #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic                    hold,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_idx,
  output logic                    grant_any
);

  localparam int IW = $clog2(NREQ);

  // One extra bit so ptr+k never overflows before the modulo fold.
  logic [IW:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    if (!hold) begin
      for (int k = 0; k < NREQ; k++) begin
        cand = {1'b0, ptr} + (IW+1)'(k);
        if (cand >= (IW+1)'(NREQ)) begin
          cand = cand - (IW+1)'(NREQ);
        end
        if (!grant_any && req[cand[IW-1:0]]) begin
          grant_any             = 1'b1;
          grant_idx             = cand[IW-1:0];
          grant[cand[IW-1:0]]   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fpu_addsub_arbiter.sv
// Shares one fixed-latency FP add/sub pipeline among NREQ clients: round-robin
// issue, tag tracking aligned to the pipe latency, and result routing.
module fpu_addsub_arbiter
  import fpu_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int LATENCY = 4,
  parameter int W       = FPU_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_op,
  output logic              pipe_in_valid,
  output logic [W-1:0]      pipe_a,
  output logic [W-1:0]      pipe_b,
  output logic              pipe_op,
  input  logic [W-1:0]      pipe_result,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_data,
  output logic              busy,
  output logic [15:0]       issued_cnt
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0]         ptr_q, ptr_d;
  logic [NREQ-1:0]       grant;
  logic [IW-1:0]         grant_idx;
  logic                  grant_any;

  logic                  pipe_in_valid_q, pipe_in_valid_d;
  logic [W-1:0]          pipe_a_q, pipe_a_d;
  logic [W-1:0]          pipe_b_q, pipe_b_d;
  logic                  pipe_op_q, pipe_op_d;

  fpu_tag_t [LATENCY:0]  trk_q, trk_d;
  logic [LATENCY:0]      trk_valid;

  logic [NREQ-1:0]       rsp_valid_q, rsp_valid_d;
  logic [W-1:0]          rsp_data_q, rsp_data_d;
  logic [15:0]           cnt_q, cnt_d;

  // Reset masks the grant so nothing is accepted while rst_n is low.
  fpu_rr_arb #(.NREQ(NREQ)) u_arb (
    .req       (req_valid),
    .hold      (hold | ~rst_n),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  genvar gi;
  generate
    for (gi = 0; gi <= LATENCY; gi++) begin : g_trk_valid
      assign trk_valid[gi] = trk_q[gi].valid;
    end
  endgenerate

  always_comb begin
    ptr_d           = ptr_q;
    pipe_in_valid_d = grant_any;
    pipe_a_d        = pipe_a_q;
    pipe_b_d        = pipe_b_q;
    pipe_op_d       = pipe_op_q;
    cnt_d           = cnt_q;
    if (grant_any) begin
      ptr_d     = (grant_idx == IW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
      pipe_a_d  = req_a[grant_idx*W +: W];
      pipe_b_d  = req_b[grant_idx*W +: W];
      pipe_op_d = req_op[grant_idx];
      cnt_d     = cnt_q + 16'd1;
    end
  end

  // Entry 0 mirrors the issue register; entry LATENCY lines up with pipe_result.
  always_comb begin
    trk_d          = '0;
    trk_d[0].valid = grant_any;
    trk_d[0].tag   = FPU_TAG_W'(grant_idx);
    for (int k = 1; k <= LATENCY; k++) begin
      trk_d[k] = trk_q[k-1];
    end
  end

  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (trk_q[LATENCY].valid) begin
      rsp_data_d = pipe_result;
      for (int k = 0; k < NREQ; k++) begin
        rsp_valid_d[k] = (trk_q[LATENCY].tag == FPU_TAG_W'(k));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q           <= '0;
      pipe_in_valid_q <= 1'b0;
      pipe_a_q        <= '0;
      pipe_b_q        <= '0;
      pipe_op_q       <= 1'b0;
      trk_q           <= '0;
      rsp_valid_q     <= '0;
      rsp_data_q      <= '0;
      cnt_q           <= '0;
    end else begin
      ptr_q           <= ptr_d;
      pipe_in_valid_q <= pipe_in_valid_d;
      pipe_a_q        <= pipe_a_d;
      pipe_b_q        <= pipe_b_d;
      pipe_op_q       <= pipe_op_d;
      trk_q           <= trk_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_data_q      <= rsp_data_d;
      cnt_q           <= cnt_d;
    end
  end

  assign req_ready     = grant;
  assign pipe_in_valid = pipe_in_valid_q;
  assign pipe_a        = pipe_a_q;
  assign pipe_b        = pipe_b_q;
  assign pipe_op       = pipe_op_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign issued_cnt    = cnt_q;
  assign busy          = rst_n & (pipe_in_valid_q | (|trk_valid));

endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// Bench for fpu_addsub_arbiter: directed scenarios plus random traffic checked
// against a cycle-scheduled reference model and a real-arithmetic datapath.
module tb_fpu_addsub_arbiter;

  localparam int NREQ = 4;
  localparam int LAT  = 4;
  localparam int W    = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              hold = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_op = '0;
  logic [NREQ*W-1:0] req_a = '0;
  logic [NREQ*W-1:0] req_b = '0;
  logic [NREQ-1:0]   req_ready;
  logic              pipe_in_valid;
  logic [W-1:0]      pipe_a, pipe_b;
  logic              pipe_op;
  logic [W-1:0]      pipe_result;
  logic [NREQ-1:0]   rsp_valid;
  logic [W-1:0]      rsp_data;
  logic              busy;
  logic [15:0]       issued_cnt;

  fpu_addsub_arbiter #(.NREQ(NREQ), .LATENCY(LAT), .W(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .hold          (hold),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_op        (req_op),
    .pipe_in_valid (pipe_in_valid),
    .pipe_a        (pipe_a),
    .pipe_b        (pipe_b),
    .pipe_op       (pipe_op),
    .pipe_result   (pipe_result),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .busy          (busy),
    .issued_cnt    (issued_cnt)
  );

  always #5 clk = ~clk;

  // Single-precision <-> real for normal numbers and zero.
  function automatic real sp2r(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:0] == 31'd0) return 0.0;
    d = {x[31], 11'(int'(x[30:23]) - 127 + 1023), x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return 32'd0;
    return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
  endfunction

  function automatic logic [31:0] fp_addsub(input logic [31:0] a, input logic [31:0] b,
                                            input logic op);
    return r2sp(op ? (sp2r(a) - sp2r(b)) : (sp2r(a) + sp2r(b)));
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    r[31]    = 1'($urandom_range(0, 1));
    r[30:23] = 8'($urandom_range(120, 134));
    r[22:0]  = 23'($urandom);
    return r;
  endfunction

  // Fixed-latency datapath stand-in: result is on pipe_result LAT cycles after issue.
  logic [W-1:0] dp_q [1:LAT];
  always @(posedge clk) begin
    dp_q[1] <= pipe_in_valid ? fp_addsub(pipe_a, pipe_b, pipe_op) : 32'hDEADBEEF;
    for (int k = 2; k <= LAT; k++) dp_q[k] <= dp_q[k-1];
  end
  assign pipe_result = dp_q[LAT];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference model state: expected responses are scheduled by absolute cycle.
  int           cyc = 0;
  int           m_ptr = 0;
  logic [15:0]  m_cnt = '0;
  logic         e_piv = 1'b0;
  logic [W-1:0] e_pa = '0, e_pb = '0;
  logic         e_pop = 1'b0;
  logic [W-1:0] e_rdata = '0;
  bit           sv [64];
  int           st [64];
  logic [W-1:0] sd [64];
  logic [W-1:0] a_v [NREQ];
  logic [W-1:0] b_v [NREQ];
  logic         op_v [NREQ];
  bit           fix_ops = 1'b0;
  logic [NREQ-1:0] obs_ready;

  task automatic model_reset();
    m_ptr   = 0;
    m_cnt   = '0;
    e_piv   = 1'b0;
    e_pa    = '0;
    e_pb    = '0;
    e_pop   = 1'b0;
    e_rdata = '0;
    for (int k = 0; k < 64; k++) sv[k] = 1'b0;
  endtask

  task automatic step(input logic [NREQ-1:0] rv, input logic h, input logic rn);
    logic [NREQ-1:0] exp_rv;
    logic [NREQ-1:0] exp_ready;
    bit              exp_busy;
    int              win;
    int              s;
    @(posedge clk);
    #1;
    cyc++;
    s      = cyc % 64;
    exp_rv = '0;
    if (sv[s]) begin
      exp_rv[st[s]] = 1'b1;
      e_rdata       = sd[s];
      sv[s]         = 1'b0;
    end
    exp_busy = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) if (sv[(cyc + k) % 64]) exp_busy = 1'b1;
    chk("pipe_in_valid", 64'(pipe_in_valid), 64'(e_piv));
    chk("pipe_a", 64'(pipe_a), 64'(e_pa));
    chk("pipe_b", 64'(pipe_b), 64'(e_pb));
    chk("pipe_op", 64'(pipe_op), 64'(e_pop));
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    chk("rsp_data", 64'(rsp_data), 64'(e_rdata));
    chk("busy", 64'(busy), 64'(exp_busy));
    chk("issued_cnt", 64'(issued_cnt), 64'(m_cnt));

    for (int i = 0; i < NREQ; i++) begin
      a_v[i]  = fix_ops ? 32'h3F800000 : rand_fp();
      b_v[i]  = fix_ops ? 32'h40000000 : rand_fp();
      op_v[i] = fix_ops ? 1'b0 : 1'($urandom_range(0, 1));
      req_a[i*W +: W] = a_v[i];
      req_b[i*W +: W] = b_v[i];
      req_op[i]       = op_v[i];
    end
    req_valid = rv;
    hold      = h;
    rst_n     = rn;
    #1;
    win = -1;
    if (rn && !h) begin
      for (int k = 0; k < NREQ; k++) begin
        if (win < 0 && rv[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
      end
    end
    exp_ready = '0;
    if (win >= 0) exp_ready[win] = 1'b1;
    obs_ready = req_ready;
    chk("req_ready", 64'(req_ready), 64'(exp_ready));

    if (!rn) begin
      model_reset();
    end else if (win >= 0) begin
      m_ptr = (win + 1) % NREQ;
      m_cnt = m_cnt + 16'd1;
      e_piv = 1'b1;
      e_pa  = a_v[win];
      e_pb  = b_v[win];
      e_pop = op_v[win];
      s     = (cyc + LAT + 2) % 64;
      sv[s] = 1'b1;
      st[s] = win;
      sd[s] = fp_addsub(a_v[win], b_v[win], op_v[win]);
    end else begin
      e_piv = 1'b0;
    end
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    // Reset with requests pending: nothing granted.
    step(4'hF, 1'b0, 1'b0);
    step(4'hF, 1'b0, 1'b0);
    chk("ready_in_reset", 64'(obs_ready), 64'h0);

    // Single request with known operands.
    fix_ops = 1'b1;
    step(4'b0001, 1'b0, 1'b1);
    chk("single_ready", 64'(obs_ready), 64'h1);
    fix_ops = 1'b0;
    step(4'b0000, 1'b0, 1'b1);
    chk("single_pipe_a", 64'(pipe_a), 64'h3F800000);
    chk("single_pipe_b", 64'(pipe_b), 64'h40000000);
    for (int k = 0; k < 5; k++) step(4'b0000, 1'b0, 1'b1);
    chk("single_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("single_rsp_data", 64'(rsp_data), 64'h40400000);
    chk("single_cnt", 64'(issued_cnt), 64'd1);

    // All four continuously valid from a fresh pointer.
    step(4'b0000, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      step(4'hF, 1'b0, 1'b1);
      chk("rr_grant", 64'(obs_ready), 64'(1 << (k % 4)));
    end
    for (int k = 0; k < 6; k++) begin
      step(4'b0000, 1'b0, 1'b1);
      chk("rr_rsp", 64'(rsp_valid), 64'(1 << (k % 4)));
    end

    // Pointer fairness: after requester 2, 3 goes before 1.
    step(4'b0100, 1'b0, 1'b1);
    chk("fair_g2", 64'(obs_ready), 64'b0100);
    step(4'b1010, 1'b0, 1'b1);
    chk("fair_g3", 64'(obs_ready), 64'b1000);
    step(4'b1010, 1'b0, 1'b1);
    chk("fair_g1", 64'(obs_ready), 64'b0010);

    // Hold with an op in flight; grant as soon as hold falls.
    step(4'b0001, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(4'b0010, 1'b1, 1'b1);
      chk("hold_ready", 64'(obs_ready), 64'h0);
    end
    step(4'b0010, 1'b0, 1'b1);
    chk("hold_release", 64'(obs_ready), 64'b0010);
    for (int k = 0; k < 8; k++) step(4'b0000, 1'b0, 1'b1);

    // Reset mid-flight drops in-flight results.
    step(4'b0100, 1'b0, 1'b1);
    step(4'b1000, 1'b0, 1'b1);
    step(4'b0001, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step(4'b0000, 1'b0, 1'b1);
      chk("rst_rsp_quiet", 64'(rsp_valid), 64'h0);
    end
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_cnt", 64'(issued_cnt), 64'h0);
    step(4'b1010, 1'b0, 1'b1);
    chk("rst_first_grant", 64'(obs_ready), 64'b0010);

    // Random traffic, occasional hold and reset.
    for (int k = 0; k < 400; k++) begin
      step(4'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 49) != 0));
    end

    // Counter wrap.
    step(4'b0000, 1'b0, 1'b0);
    for (int k = 0; k < 65535; k++) step(4'hF, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    chk("cnt_ffff", 64'(issued_cnt), 64'hFFFF);
    step(4'b0100, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    chk("cnt_wrap", 64'(issued_cnt), 64'h0);
    for (int k = 0; k < 8; k++) step(4'b0000, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
